// File: rtl/spi_master_if.sv
// spi_master_if
// Bundles the byte-request handshake and the serial outputs of spi_master.
//   newd : request to send one byte (producer -> master)
//   din  : byte to send, captured when the request is accepted
//   sclk : serial clock, idle low
//   mosi : serial data, MSB first
//   cs   : chip select, active low
//   busy : frame in progress (accept edge until return to idle)
//   done : one-clock pulse at frame completion
// The master modport is used by spi_master; the slave modport is the
// producer/observer side.
`timescale 1ns/1ps

interface spi_master_if;
    logic       newd;
    logic [7:0] din;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic       busy;
    logic       done;

    modport master (
        input  newd,
        input  din,
        output sclk,
        output mosi,
        output cs,
        output busy,
        output done
    );

    modport slave (
        output newd,
        output din,
        input  sclk,
        input  mosi,
        input  cs,
        input  busy,
        input  done
    );
endinterface

// File: rtl/spi_master.sv
// spi_master
// Serialises one byte per request into a framed SPI transfer for the
// downstream slave stage: one lead-in sclk period with cs low, eight data
// periods (MSB first), and one trailing period that lets the slave finish.
// Ports:
//   clk : system clock, all state updates on its rising edge
//   rst : asynchronous active-high reset
//   bus : spi_master_if.master (newd/din in; sclk/mosi/cs/busy/done out)
// Parameter:
//   CLK_DIV : system clocks per sclk half-period (1..255)
`timescale 1ns/1ps

module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       period, period_d;
    logic [7:0]       shreg, shreg_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             half_end;

    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.cs   = cs_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    assign half_end = (cnt == CNT_LAST);

    // State register and every output flop. Reset puts the bus in its idle
    // shape immediately, which also abandons any partial frame without a
    // done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= '0;
            shreg  <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
            cs_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            period <= period_d;
            shreg  <= shreg_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
            cs_q   <= cs_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next-state and next-output logic. Every phase is timed by the same
    // half-period counter, which restarts whenever a phase boundary or an
    // sclk toggle is reached. Period 1 and period 10 carry mosi=0 so the
    // slave sees one framing period before and after the data bits.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        period_d = period;
        shreg_d  = shreg;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (bus.newd) begin
                    shreg_d = bus.din;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = LEAD;
                end
            end

            LEAD: begin
                mosi_d = 1'b0;
                if (half_end) begin
                    cnt_d    = '0;
                    sclk_d   = 1'b1;
                    period_d = 4'd1;
                    state_d  = XFER;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            XFER: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (period == 4'd10) begin
                            state_d = TRAIL;
                        end
                    end else if (period != 4'd10) begin
                        // Rising edge opens the next period; periods 2..9
                        // carry the data bits straight out of the shifter.
                        sclk_d   = 1'b1;
                        period_d = period + 4'd1;
                        if (period <= 4'd8) begin
                            mosi_d  = shreg[7];
                            shreg_d = {shreg[6:0], 1'b0};
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            TRAIL: begin
                if (half_end) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            GAP: begin
                if (half_end) begin
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    period_d = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
